// File: rtl/mesi_isc_broad_multi.sv
// mesi_isc_broad_multi: queued coherence broadcast unit driving snoops, then the initiator enable
module mesi_isc_broad_multi #(
   parameter int CPU_COUNT        = 4,
   parameter int CPU_ID_WIDTH     = 2,
   parameter int CBUS_CMD_WIDTH   = 3,
   parameter int ADDR_WIDTH       = 32,
   parameter int BROAD_TYPE_WIDTH = 2,
   parameter int BROAD_ID_WIDTH   = 5,
   parameter int FIFO_DEPTH       = 4,
   parameter int FIFO_DEPTH_LOG2  = 2,
   parameter int ALMOST_FULL_LVL  = 3,
   parameter int TIMEOUT_WIDTH    = 8,
   parameter int TIMEOUT_CYCLES   = 255
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [CPU_COUNT-1:0]                cbus_ack_array_i,
   input  logic                                broad_fifo_wr_i,
   input  logic [ADDR_WIDTH-1:0]               broad_addr_i,
   input  logic [BROAD_TYPE_WIDTH-1:0]         broad_type_i,
   input  logic [CPU_ID_WIDTH-1:0]             broad_cpu_id_i,
   input  logic [BROAD_ID_WIDTH-1:0]           broad_id_i,
   output logic [ADDR_WIDTH-1:0]               cbus_addr_o,
   output logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
   output logic                                fifo_status_full_o,
   output logic                                fifo_status_almost_full_o,
   output logic [FIFO_DEPTH_LOG2:0]            fifo_count_o,
   output logic                                busy_o,
   output logic                                timeout_o,
   output logic [BROAD_ID_WIDTH-1:0]           timeout_id_o
);
   localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_NOP      = '0;
   localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
   localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
   localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
   localparam logic [CBUS_CMD_WIDTH-1:0]   CMD_EN_RD    = CBUS_CMD_WIDTH'(4);
   localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_NOP     = '0;
   localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR      = BROAD_TYPE_WIDTH'(1);
   localparam logic [FIFO_DEPTH_LOG2:0]    DEPTH        = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);
   localparam logic [FIFO_DEPTH_LOG2:0]    AF_LVL       = (FIFO_DEPTH_LOG2+1)'(ALMOST_FULL_LVL);
   localparam logic [TIMEOUT_WIDTH-1:0]    WD_LAST      = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SNOOP, ENABLE, DROP} state_t;

   state_t                        state, state_nxt;
   logic [ADDR_WIDTH-1:0]         addr_mem [FIFO_DEPTH];
   logic [BROAD_TYPE_WIDTH-1:0]   type_mem [FIFO_DEPTH];
   logic [CPU_ID_WIDTH-1:0]       cpu_mem  [FIFO_DEPTH];
   logic [BROAD_ID_WIDTH-1:0]     id_mem   [FIFO_DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0]    wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]      count;
   logic [CPU_COUNT-1:0]          mask, mask_nxt, init_mask, acc;
   logic [TIMEOUT_WIDTH-1:0]      wd, wd_nxt;
   logic [BROAD_ID_WIDTH-1:0]     last_id;
   logic [BROAD_TYPE_WIDTH-1:0]   head_type;
   logic [CPU_ID_WIDTH-1:0]       head_cpu;
   logic [BROAD_ID_WIDTH-1:0]     head_id;
   logic [CBUS_CMD_WIDTH-1:0]     snoop_cmd, en_cmd;
   logic                          full, empty, push, pop, cpu_valid, active, tmo;

   assign head_type   = type_mem[rd_ptr];
   assign head_cpu    = cpu_mem[rd_ptr];
   assign head_id     = id_mem[rd_ptr];
   assign cbus_addr_o = addr_mem[rd_ptr];
   assign full        = count == DEPTH;
   assign empty       = count == '0;
   assign push        = broad_fifo_wr_i && !full;
   assign cpu_valid   = int'({1'b0, head_cpu}) < CPU_COUNT;
   assign snoop_cmd   = (head_type == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP;
   assign en_cmd      = (head_type == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD;
   assign active      = state == SNOOP || state == ENABLE;
   // acks only count when they come from a CPU the current phase is waiting on
   assign acc         = (state == SNOOP) ? mask & cbus_ack_array_i :
                        (state == ENABLE) ? ~init_mask & cbus_ack_array_i : '0;
   assign tmo         = (TIMEOUT_CYCLES != 0) && active && acc == '0 && wd == WD_LAST;

   assign fifo_status_full_o        = full;
   assign fifo_status_almost_full_o = count >= AF_LVL;
   assign fifo_count_o              = count;
   assign busy_o                    = state != IDLE;
   assign timeout_o                 = tmo;
   assign timeout_id_o              = tmo ? head_id : last_id;

   // snoop targets: every CPU except a valid initiator, all CPUs otherwise
   always_comb begin
      for (int i = 0; i < CPU_COUNT; i++) init_mask[i] = !(cpu_valid && int'({1'b0, head_cpu}) == i);
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_mem[i] <= '0;
            type_mem[i] <= '0;
            cpu_mem[i]  <= '0;
            id_mem[i]   <= '0;
         end
      end else begin
         if (push) begin
            addr_mem[wr_ptr] <= broad_addr_i;
            type_mem[wr_ptr] <= broad_type_i;
            cpu_mem[wr_ptr]  <= broad_cpu_id_i;
            id_mem[wr_ptr]   <= broad_id_i;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (FIFO_DEPTH_LOG2+1)'(push) - (FIFO_DEPTH_LOG2+1)'(pop);
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   // pending mask, watchdog and the held timeout id
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask    <= '0;
         wd      <= '0;
         last_id <= '0;
      end else begin
         mask <= mask_nxt;
         wd   <= wd_nxt;
         if (tmo) last_id <= head_id;
      end
   end

   // next state, pop and pending-mask/watchdog updates
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      mask_nxt  = mask & ~cbus_ack_array_i;
      wd_nxt    = (!active || acc != '0) ? '0 : wd + 1'b1;
      case (state)
         IDLE: if (!empty) begin
            state_nxt = (head_type == TYPE_NOP) ? DROP : SNOOP;
            mask_nxt  = init_mask;
            wd_nxt    = '0;
         end
         DROP: begin
            pop       = 1'b1;
            state_nxt = IDLE;
         end
         SNOOP: if (tmo) begin
            pop       = 1'b1;
            state_nxt = IDLE;
         end else if (mask_nxt == '0) begin
            pop       = !cpu_valid;
            state_nxt = cpu_valid ? ENABLE : IDLE;
            wd_nxt    = '0;
         end
         ENABLE: if (tmo || acc != '0) begin
            pop       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // per-CPU commands; a watchdog retire silences every bus in that cycle
   always_comb begin
      cbus_cmd_array_o = '0;
      for (int i = 0; i < CPU_COUNT; i++)
         cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
            tmo ? CMD_NOP :
            (state == SNOOP && mask[i]) ? snoop_cmd :
            (state == ENABLE && !init_mask[i]) ? en_cmd : CMD_NOP;
   end
endmodule

// File: tb/tb_mesi_isc_broad_multi.sv
// tb_mesi_isc_broad_multi: directed checks of the broadcast unit in three configurations
module tb_mesi_isc_broad_multi;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic [1:0]  btype, cpu;
   logic [4:0]  bid;
   logic        wr0, wr1, wr2;
   logic [3:0]  ack0, ack1;
   logic [2:0]  ack2;
   logic [31:0] a0, a1, a2;
   logic [11:0] c0, c1;
   logic [8:0]  c2;
   logic        full0, full1, full2, af0, af1, af2, busy0, busy1, busy2, to0, to1, to2;
   logic [2:0]  cnt0, cnt1, cnt2;
   logic [4:0]  tid0, tid1, tid2;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mesi_isc_broad_multi u0 (
      .clk(clk), .rst_n(rst_n), .cbus_ack_array_i(ack0), .broad_fifo_wr_i(wr0),
      .broad_addr_i(addr), .broad_type_i(btype), .broad_cpu_id_i(cpu), .broad_id_i(bid),
      .cbus_addr_o(a0), .cbus_cmd_array_o(c0), .fifo_status_full_o(full0),
      .fifo_status_almost_full_o(af0), .fifo_count_o(cnt0), .busy_o(busy0),
      .timeout_o(to0), .timeout_id_o(tid0));

   mesi_isc_broad_multi #(.TIMEOUT_CYCLES(16)) u1 (
      .clk(clk), .rst_n(rst_n), .cbus_ack_array_i(ack1), .broad_fifo_wr_i(wr1),
      .broad_addr_i(addr), .broad_type_i(btype), .broad_cpu_id_i(cpu), .broad_id_i(bid),
      .cbus_addr_o(a1), .cbus_cmd_array_o(c1), .fifo_status_full_o(full1),
      .fifo_status_almost_full_o(af1), .fifo_count_o(cnt1), .busy_o(busy1),
      .timeout_o(to1), .timeout_id_o(tid1));

   mesi_isc_broad_multi #(.CPU_COUNT(3)) u2 (
      .clk(clk), .rst_n(rst_n), .cbus_ack_array_i(ack2), .broad_fifo_wr_i(wr2),
      .broad_addr_i(addr), .broad_type_i(btype), .broad_cpu_id_i(cpu), .broad_id_i(bid),
      .cbus_addr_o(a2), .cbus_cmd_array_o(c2), .fifo_status_full_o(full2),
      .fifo_status_almost_full_o(af2), .fifo_count_o(cnt2), .busy_o(busy2),
      .timeout_o(to2), .timeout_id_o(tid2));

   // one cycle: inputs change 1 time unit after the rising edge, pulses default low
   task automatic tick();
      @(posedge clk);
      #1;
      wr0 = 0; wr1 = 0; wr2 = 0; ack0 = 0; ack1 = 0; ack2 = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; wr0 = 0; wr1 = 0; wr2 = 0; ack0 = 0; ack1 = 0; ack2 = 0;
      addr = 0; btype = 0; cpu = 0; bid = 0;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (c0 !== 12'h000) begin errors++; $display("FAIL reset_cmds got %h exp %h", c0, 12'h000); end
      checks++; if ({full0, af0, busy0, to0, cnt0} !== 7'b0) begin errors++; $display("FAIL reset_status got %b exp %b", {full0, af0, busy0, to0, cnt0}, 7'b0); end
      checks++; if (a0 !== 32'h0 || tid0 !== 5'h0) begin errors++; $display("FAIL reset_addr_id got %h/%h exp 0/0", a0, tid0); end
      checks++; if (c2 !== 9'h000 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_others got %h/%b exp 000/0", c2, busy1); end
      rst_n = 1;
   endtask

   task automatic test_wr_flow();
      tick(); wr0 = 1; addr = 32'h0000_1000; btype = 1; cpu = 1; bid = 5;
      tick(); #2;
      checks++; if (cnt0 !== 3'd1 || busy0 !== 1'b0) begin errors++; $display("FAIL wr_queued got cnt %0d busy %b exp 1 0", cnt0, busy0); end
      checks++; if (a0 !== 32'h0000_1000) begin errors++; $display("FAIL wr_head_addr got %h exp %h", a0, 32'h0000_1000); end
      tick(); #2;
      checks++; if (c0 !== 12'h241 || busy0 !== 1'b1) begin errors++; $display("FAIL wr_snoop_t2 got %h/%b exp 241/1", c0, busy0); end
      tick(); ack0 = 4'b0001; #2;
      checks++; if (c0 !== 12'h241) begin errors++; $display("FAIL wr_snoop_t3 got %h exp %h", c0, 12'h241); end
      tick(); ack0 = 4'b0010; #2;
      checks++; if (c0 !== 12'h240) begin errors++; $display("FAIL wr_cpu0_cleared got %h exp %h", c0, 12'h240); end
      tick(); ack0 = 4'b1000; #2;
      checks++; if (c0 !== 12'h240) begin errors++; $display("FAIL wr_nonpending_ack got %h exp %h", c0, 12'h240); end
      tick(); ack0 = 4'b0100; #2;
      checks++; if (c0 !== 12'h040) begin errors++; $display("FAIL wr_cpu3_cleared got %h exp %h", c0, 12'h040); end
      tick(); #2;
      checks++; if (c0 !== 12'h018) begin errors++; $display("FAIL wr_enable got %h exp %h", c0, 12'h018); end
      tick(); ack0 = 4'b0010; #2;
      checks++; if (c0 !== 12'h018 || cnt0 !== 3'd1) begin errors++; $display("FAIL wr_enable_hold got %h/%0d exp 018/1", c0, cnt0); end
      tick(); #2;
      checks++; if (cnt0 !== 3'd0 || busy0 !== 1'b0 || c0 !== 12'h000) begin errors++; $display("FAIL wr_done got cnt %0d busy %b cmd %h exp 0 0 000", cnt0, busy0, c0); end
   endtask

   task automatic test_nop();
      tick(); wr0 = 1; addr = 32'h0000_2000; btype = 0; cpu = 2; bid = 3;
      tick(); #2;
      checks++; if (cnt0 !== 3'd1 || busy0 !== 1'b0) begin errors++; $display("FAIL nop_queued got cnt %0d busy %b exp 1 0", cnt0, busy0); end
      tick(); #2;
      checks++; if (busy0 !== 1'b1 || c0 !== 12'h000) begin errors++; $display("FAIL nop_drop got busy %b cmd %h exp 1 000", busy0, c0); end
      tick(); #2;
      checks++; if (cnt0 !== 3'd0 || busy0 !== 1'b0 || c0 !== 12'h000) begin errors++; $display("FAIL nop_done got cnt %0d busy %b cmd %h exp 0 0 000", cnt0, busy0, c0); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 5; k++) begin
         tick(); wr0 = 1; addr = 32'h0000_A000 + 32'(k * 16); btype = 2; cpu = 0; bid = 5'(10 + k); #2;
         if (k == 2) begin
            checks++; if (cnt0 !== 3'd2 || af0 !== 1'b0) begin errors++; $display("FAIL b2b_two got cnt %0d af %b exp 2 0", cnt0, af0); end
         end
         if (k == 3) begin
            checks++; if (cnt0 !== 3'd3 || af0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL b2b_three got cnt %0d af %b full %b exp 3 1 0", cnt0, af0, full0); end
         end
         if (k == 4) begin
            checks++; if (cnt0 !== 3'd4 || full0 !== 1'b1) begin errors++; $display("FAIL b2b_four got cnt %0d full %b exp 4 1", cnt0, full0); end
         end
      end
      tick(); #2;
      checks++; if (cnt0 !== 3'd4 || full0 !== 1'b1) begin errors++; $display("FAIL b2b_fifth_dropped got cnt %0d full %b exp 4 1", cnt0, full0); end
      for (int k = 0; k < 4; k++) begin
         tick(); ack0 = 4'b1110; #2;
         checks++; if (a0 !== 32'h0000_A000 + 32'(k * 16) || c0 !== 12'h490) begin errors++; $display("FAIL b2b_drain_snoop%0d got %h/%h exp %h/490", k, a0, c0, 32'h0000_A000 + 32'(k * 16)); end
         tick(); ack0 = 4'b0001; #2;
         checks++; if (c0 !== 12'h004) begin errors++; $display("FAIL b2b_drain_en%0d got %h exp %h", k, c0, 12'h004); end
         tick(); #2;
         checks++; if (busy0 !== 1'b0 || cnt0 !== 3'(3 - k)) begin errors++; $display("FAIL b2b_drain_idle%0d got busy %b cnt %0d exp 0 %0d", k, busy0, cnt0, 3 - k); end
      end
   endtask

   task automatic test_timeout();
      tick(); wr1 = 1; addr = 32'h0000_3000; btype = 2; cpu = 0; bid = 7;
      tick(); wr1 = 1; addr = 32'h0000_4000; btype = 1; cpu = 3; bid = 8;
      tick(); #2;
      checks++; if (c1 !== 12'h490) begin errors++; $display("FAIL to_snoop got %h exp %h", c1, 12'h490); end
      tick(); ack1 = 4'b1010;
      repeat (15) tick();
      #2;
      checks++; if (to1 !== 1'b0 || c1 !== 12'h080 || tid1 !== 5'd0) begin errors++; $display("FAIL to_before got to %b cmd %h id %0d exp 0 080 0", to1, c1, tid1); end
      tick(); #2;
      checks++; if (to1 !== 1'b1 || tid1 !== 5'd7 || c1 !== 12'h000) begin errors++; $display("FAIL to_pulse got to %b id %0d cmd %h exp 1 7 000", to1, tid1, c1); end
      tick(); #2;
      checks++; if (to1 !== 1'b0 || tid1 !== 5'd7 || busy1 !== 1'b0 || cnt1 !== 3'd1) begin errors++; $display("FAIL to_after got to %b id %0d busy %b cnt %0d exp 0 7 0 1", to1, tid1, busy1, cnt1); end
      tick(); #2;
      checks++; if (busy1 !== 1'b1 || a1 !== 32'h0000_4000 || c1 !== 12'h049) begin errors++; $display("FAIL to_next_snoop got busy %b addr %h cmd %h exp 1 4000 049", busy1, a1, c1); end
      repeat (14) tick();
      tick(); ack1 = 4'b0111; #2;
      checks++; if (to1 !== 1'b0 || c1 !== 12'h049) begin errors++; $display("FAIL to_ack_wins got to %b cmd %h exp 0 049", to1, c1); end
      tick(); ack1 = 4'b1000; #2;
      checks++; if (c1 !== 12'h600) begin errors++; $display("FAIL to_next_enable got %h exp %h", c1, 12'h600); end
      tick(); #2;
      checks++; if (cnt1 !== 3'd0 || busy1 !== 1'b0 || tid1 !== 5'd7) begin errors++; $display("FAIL to_next_done got cnt %0d busy %b id %0d exp 0 0 7", cnt1, busy1, tid1); end
   endtask

   task automatic test_invalid_initiator();
      tick(); wr2 = 1; addr = 32'h0000_5000; btype = 1; cpu = 3; bid = 9;
      tick(); #2;
      checks++; if (cnt2 !== 3'd1 || busy2 !== 1'b0) begin errors++; $display("FAIL inv_queued got cnt %0d busy %b exp 1 0", cnt2, busy2); end
      tick(); ack2 = 3'b011; #2;
      checks++; if (c2 !== 9'h049) begin errors++; $display("FAIL inv_snoop_all got %h exp %h", c2, 9'h049); end
      tick(); ack2 = 3'b100; #2;
      checks++; if (c2 !== 9'h040 || busy2 !== 1'b1) begin errors++; $display("FAIL inv_snoop_last got %h/%b exp 040/1", c2, busy2); end
      tick(); #2;
      checks++; if (c2 !== 9'h000 || busy2 !== 1'b0 || cnt2 !== 3'd0) begin errors++; $display("FAIL inv_no_enable got cmd %h busy %b cnt %0d exp 000 0 0", c2, busy2, cnt2); end
   endtask

   task automatic test_reset_mid();
      tick(); wr0 = 1; addr = 32'h0000_6000; btype = 1; cpu = 1; bid = 4;
      tick(); wr0 = 1; addr = 32'h0000_7000;
      tick(); #2;
      checks++; if (c0 !== 12'h241 || cnt0 !== 3'd2) begin errors++; $display("FAIL rstmid_pre got %h/%0d exp 241/2", c0, cnt0); end
      rst_n = 0; #1;
      checks++; if (c0 !== 12'h000 || cnt0 !== 3'd0 || full0 !== 1'b0 || busy0 !== 1'b0 || to0 !== 1'b0) begin errors++; $display("FAIL rstmid_async got cmd %h cnt %0d full %b busy %b to %b exp 000 0 0 0 0", c0, cnt0, full0, busy0, to0); end
      @(posedge clk); #1; rst_n = 1;
      tick(); tick(); #2;
      checks++; if (cnt0 !== 3'd0 || busy0 !== 1'b0 || c0 !== 12'h000) begin errors++; $display("FAIL rstmid_after got cnt %0d busy %b cmd %h exp 0 0 000", cnt0, busy0, c0); end
   endtask

   initial begin
      test_reset();
      test_wr_flow();
      test_nop();
      test_back_to_back();
      test_timeout();
      test_invalid_initiator();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit reached");
      $fatal(1);
   end
endmodule
